axi_slave_mem: RTL

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem_pkg.sv | 18 +
 rtl/axi_slave_mem_if.sv | 42 ++++
 rtl/axi_slave_mem_ram.sv | 57 +++++
 rtl/axi_slave_mem.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_mem_pkg.sv
// Shared constants and FSM state types for the AXI slave memory.
package axi_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI write/read channel bundle between a master and the slave memory.
interface axi_slave_mem_if;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_slave_mem_ram.sv
// Byte-enable word array: one AXI write port, one AXI read port, one backdoor port.
// Contents start at FILL and are never touched by reset; only the read registers are.
module axi_slave_mem_ram #(
  parameter int unsigned  MEM_WORDS = 4096,
  parameter logic [31:0]  FILL      = 32'hFFFFFFFF,
  localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [31:0]   i_wr_data,
  input  logic [3:0]    i_wr_strb,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_idx,
  output logic [31:0]   o_rd_data,
  input  logic          i_bd_we,
  input  logic [AW-1:0] i_bd_idx,
  input  logic [31:0]   i_bd_wdata,
  output logic [31:0]   o_bd_rdata
);

  logic [31:0] r_mem [MEM_WORDS] = '{default: FILL};
  logic [31:0] r_rd_data;
  logic [31:0] r_bd_rdata;

  // Array update: AXI byte lanes first, backdoor full word last so it wins a collision.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_strb[b]) begin
          r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
    if (i_bd_we) begin
      r_mem[i_bd_idx] <= i_bd_wdata;
    end
  end

  // Registered reads; values sampled before any same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_bd_rdata <= '0;
    end else begin
      if (i_rd_en) begin
        r_rd_data <= r_mem[i_rd_idx];
      end
      r_bd_rdata <= r_mem[i_bd_idx];
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_bd_rdata = r_bd_rdata;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave memory: INCR-only bursts with 4-byte beats, one write and one read
// outstanding, independent write/read FSMs and a backdoor word port.
// MEM_WORDS must be a power of two between 2 and 2**29.
module axi_slave_mem #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] FILL      = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  axi_slave_mem_if.slave   s_axi,
  input  logic             bd_we,
  input  logic [31:0]      bd_addr,
  input  logic [31:0]      bd_wdata,
  output logic [31:0]      bd_rdata
);

  import axi_slave_mem_pkg::*;

  localparam int unsigned AW = $clog2(MEM_WORDS);

  wr_state_e     r_wr_state;
  logic          r_awready;
  logic          r_wready;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic [AW-1:0] r_wr_idx;
  logic [7:0]    r_wr_len;
  logic [7:0]    r_wr_cnt;
  logic          r_wr_err;

  rd_state_e     r_rd_state;
  logic          r_arready;
  logic          r_rvalid;
  logic          r_rlast;
  logic [AW-1:0] r_rd_idx;
  logic [7:0]    r_rd_len;
  logic [7:0]    r_rd_cnt;

  logic          w_wr_en;
  logic          w_wr_last_beat;
  logic          w_beat_err;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_rd_data;
  logic          w_unused_addr;

  assign w_wr_en        = r_wready && s_axi.wvalid;
  assign w_wr_last_beat = (r_wr_cnt == r_wr_len);
  // wlast must coincide exactly with the counted final beat.
  assign w_beat_err     = (s_axi.wlast != w_wr_last_beat);

  assign w_ar_hs  = (r_rd_state == R_IDLE) && r_arready && s_axi.arvalid;
  assign w_r_hs   = r_rvalid && s_axi.rready;
  // Fetch the first beat on AR handshake, then the next beat on each non-final handshake.
  assign w_rd_en  = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_rd_idx = w_ar_hs ? s_axi.araddr[AW+1:2] : r_rd_idx;

  assign w_unused_addr = ^{s_axi.awaddr[31:AW+2], s_axi.awaddr[1:0],
                           s_axi.araddr[31:AW+2], s_axi.araddr[1:0],
                           bd_addr[31:AW+2], bd_addr[1:0]};

  // Write channel FSM: address, data beats, response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_idx   <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      unique case (r_wr_state)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (r_awready && s_axi.awvalid) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_wr_idx   <= s_axi.awaddr[AW+1:2];
            r_wr_len   <= s_axi.awlen;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
            r_wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wr_en) begin
            r_wr_idx <= r_wr_idx + 1'b1;
            r_wr_cnt <= r_wr_cnt + 8'd1;
            r_wr_err <= r_wr_err | w_beat_err;
            if (w_wr_last_beat) begin
              r_wready   <= 1'b0;
              r_bvalid   <= 1'b1;
              r_bresp    <= (r_wr_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              r_wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awready  <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: address, then beats held until each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rd_idx   <= '0;
      r_rd_len   <= '0;
      r_rd_cnt   <= '0;
    end else begin
      unique case (r_rd_state)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rlast    <= (s_axi.arlen == 8'd0);
            r_rd_idx   <= s_axi.araddr[AW+1:2] + 1'b1;
            r_rd_len   <= s_axi.arlen;
            r_rd_cnt   <= '0;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid   <= 1'b0;
              r_rlast    <= 1'b0;
              r_arready  <= 1'b1;
              r_rd_state <= R_IDLE;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
              r_rd_cnt <= r_rd_cnt + 8'd1;
              r_rlast  <= ((r_rd_cnt + 8'd1) == r_rd_len);
            end
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  axi_slave_mem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .FILL      (FILL)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_wr_idx),
    .i_wr_data  (s_axi.wdata),
    .i_wr_strb  (s_axi.wstrb),
    .i_rd_en    (w_rd_en),
    .i_rd_idx   (w_rd_idx),
    .o_rd_data  (w_rd_data),
    .i_bd_we    (bd_we),
    .i_bd_idx   (bd_addr[AW+1:2]),
    .i_bd_wdata (bd_wdata),
    .o_bd_rdata (bd_rdata)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rdata   = w_rd_data;
  assign s_axi.rresp   = RESP_OKAY;

endmodule
